mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter that lets NREQ warp-side requesters share one read port (raddr0/rdata0) and the 64-byte masked write port (wen64/waddr64/wdata64/mask) of the main memory.
- Accepts at most one request per cycle and drives registered memory-side signals.
- Returns read data to the requester with a fixed two-cycle latency.
- Sits between the warp execution units and the memory array; the shared 2-byte port and ldtex path are not touched.

Parameters:
- NREQ, 4, number of requesters; minimum 2.
- PW, 2, width of the round-robin pointer; must satisfy 2^PW >= NREQ.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_write  input  NREQ  1 = masked line write, 0 = line read.
- req_addr  input  11*NREQ  line address [15:5]; requester i in bits [11*i+10 : 11*i].
- req_wdata  input  512*NREQ  write line data; requester i in bits [512*i+511 : 512*i].
- req_mask  input  32*NREQ  per-halfword write mask, bit k = halfword k.
- req_ready  output  NREQ  one-hot grant, combinational, for the current cycle.
- resp_valid  output  NREQ  one-hot, one-cycle pulse, read data valid.
- resp_data  output  512  read line data, shared by all requesters.
- raddr0  output  11  memory read address.
- rdata0  input  512  memory read data, combinational from raddr0.
- wen64  output  1  memory line write enable.
- waddr64  output  11  memory line write address.
- wdata64  output  512  memory line write data.
- mask  output  32  memory halfword write mask.
- conflict_cnt  output  16  count of cycles with 2 or more valid requests.

Behaviour:
- Handshake:
  - Transfer occurs when req_valid[i] && req_ready[i].
  - req_ready is one-hot or zero. It is zero when req_valid is all zeros.
  - A requester must hold its request fields stable while valid and not ready.
- Arbitration:
  - Pointer ptr holds the index of the last granted requester.
  - The search starts at ptr+1 mod NREQ and grants the first valid requester found.
  - ptr updates to the granted index only on a grant. An idle cycle leaves ptr unchanged.
- Issue stage (registered): on a grant at cycle T, the memory-side signals are driven during cycle T+1.
  - Write:
    - wen64=1 for exactly one cycle.
    - waddr64, wdata64 and mask are copied from the granted requester.
    - Memory commits at the end of T+1.
  - Read:
    - raddr0 = granted address during T+1; wen64=0.
    - rdata0 is captured into resp_data at the end of T+1.
    - resp_valid[i] pulses during T+2; resp_data holds until the next read capture.
  - Idle:
    - wen64=0; raddr0, waddr64, wdata64 and mask hold their last values.
    - resp_valid=0.
- Back-to-back operation:
  - Full throughput is one request per cycle.
  - A read granted the cycle after a write to the same line is issued after the write commits, so it returns the new data. No forwarding is needed.
- No response backpressure: the requester must accept resp_valid when it is asserted.
- conflict_cnt:
  - Increments every cycle in which popcount(req_valid) >= 2.
  - Saturates at 16'hFFFF. There is no wrap.
- Reset values (asynchronous, rst=1):
  - ptr=NREQ-1, so requester 0 has first priority.
  - wen64=0, waddr64=0, wdata64=0, mask=0, raddr0=0.
  - resp_valid=0, resp_data=0, conflict_cnt=0.
  - req_ready is forced 0 while rst is high.
- Reset mid-operation:
  - An issue-stage write not yet committed is dropped, because wen64 clears asynchronously.
  - An in-flight read produces no resp_valid.
  - Requesters must reissue after rst deasserts.
- Edge cases:
  - req_mask=0 on a write still pulses wen64; memory contents are unchanged.
  - Reads ignore req_mask and req_wdata.

Test Plan:
- Read path: preload line 0x010; req0 read addr 0x010 at T → req_ready[0]=1 at T; raddr0=0x010 at T+1; resp_valid=4'b0001 at T+2 with resp_data = preloaded line.
- Masked write then read: req1 write addr 0x020, wdata all 16'hBEEF, mask 32'h0000_0001 at T; req1 read 0x020 at T+1 → wen64 pulse at T+1 only. Read returns halfword 0 = 16'hBEEF and halfwords 1-31 unchanged, at T+3.
- Round-robin: all 4 requesters hold reads from reset → grants 0,1,2,3,0 on consecutive cycles. When only req2 and req0 are valid after granting 2, the next grant is 0. conflict_cnt increments each contended cycle.
- Idle hold: grant one write, then 3 idle cycles → wen64=0, resp_valid=0, and waddr64/mask unchanged.
- Reset mid-flight: write granted at T, rst asserted mid T+1 → wen64 drops immediately and the target line is unchanged. After release, ptr=3 and the first grant goes to req0.
- Saturation: hold 2 requesters valid for 70000 cycles → conflict_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-byte read port and one masked line-write port
// among NREQ requesters; registered issue stage, fixed two-cycle read latency.
module mem_port_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ-1:0]     req_write,
  input  logic [11*NREQ-1:0]  req_addr,
  input  logic [512*NREQ-1:0] req_wdata,
  input  logic [32*NREQ-1:0]  req_mask,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     resp_valid,
  output logic [511:0]        resp_data,
  output logic [10:0]         raddr0,
  input  logic [511:0]        rdata0,
  output logic                wen64,
  output logic [10:0]         waddr64,
  output logic [511:0]        wdata64,
  output logic [31:0]         mask,
  output logic [15:0]         conflict_cnt
);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wen64_q, wen64_d;
  logic [10:0]     waddr_q, waddr_d;
  logic [511:0]    wdata_q, wdata_d;
  logic [31:0]     mask_q, mask_d;
  logic [10:0]     raddr_q, raddr_d;
  logic [NREQ-1:0] rd_pend_q, rd_pend_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [511:0]    resp_data_q, resp_data_d;
  logic [15:0]     conflict_q, conflict_d;

  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] grant_oh;
  logic            sel_write;
  logic [10:0]     sel_addr;
  logic [511:0]    sel_wdata;
  logic [31:0]     sel_mask;
  int unsigned     valid_cnt;
  logic            contended;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_oh = grant_vld ? (NREQ'(1) << grant_idx) : '0;
  end

  assign req_ready = rst ? '0 : grant_oh;

  always_comb begin
    sel_write = req_write[grant_idx];
    sel_addr  = req_addr[grant_idx*11 +: 11];
    sel_wdata = req_wdata[grant_idx*512 +: 512];
    sel_mask  = req_mask[grant_idx*32 +: 32];
  end

  always_comb begin
    valid_cnt = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      valid_cnt = valid_cnt + 32'(req_valid[i]);
    end
    contended = (valid_cnt >= 2);
  end

  always_comb begin
    ptr_d        = ptr_q;
    wen64_d      = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    raddr_d      = raddr_q;
    rd_pend_d    = '0;
    resp_valid_d = rd_pend_q;
    resp_data_d  = resp_data_q;
    conflict_d   = conflict_q;

    if (grant_vld) begin
      ptr_d = grant_idx;
      if (sel_write) begin
        wen64_d = 1'b1;
        waddr_d = sel_addr;
        wdata_d = sel_wdata;
        mask_d  = sel_mask;
      end else begin
        raddr_d   = sel_addr;
        rd_pend_d = grant_oh;
      end
    end

    // rdata0 follows raddr0 combinationally, so capture in the issue cycle.
    if (|rd_pend_q) begin
      resp_data_d = rdata0;
    end

    if (contended && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= PW'(NREQ - 1);
      wen64_q      <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      raddr_q      <= '0;
      rd_pend_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      conflict_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      wen64_q      <= wen64_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      raddr_q      <= raddr_d;
      rd_pend_q    <= rd_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      conflict_q   <= conflict_d;
    end
  end

  assign wen64        = wen64_q;
  assign waddr64      = waddr_q;
  assign wdata64      = wdata_q;
  assign mask         = mask_q;
  assign raddr0       = raddr_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 2048-line masked memory.
module tb_mem_port_arbiter;

  logic           clk;
  logic           rst;
  logic [3:0]     req_valid;
  logic [3:0]     req_write;
  logic [43:0]    req_addr;
  logic [2047:0]  req_wdata;
  logic [127:0]   req_mask;
  logic [3:0]     req_ready;
  logic [3:0]     resp_valid;
  logic [511:0]   resp_data;
  logic [10:0]    raddr0;
  logic [511:0]   rdata0;
  logic           wen64;
  logic [10:0]    waddr64;
  logic [511:0]   wdata64;
  logic [31:0]    mask;
  logic [15:0]    conflict_cnt;

  logic [511:0] mem [2048];
  int total;
  int bad;

  mem_port_arbiter #(.NREQ(4), .PW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .raddr0(raddr0), .rdata0(rdata0),
    .wen64(wen64), .waddr64(waddr64), .wdata64(wdata64), .mask(mask),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata0 = mem[raddr0];

  always @(posedge clk) begin
    if (wen64) begin
      for (int k = 0; k < 32; k++) begin
        if (mask[k]) mem[waddr64][16*k +: 16] <= wdata64[16*k +: 16];
      end
    end
  end

  function automatic logic [511:0] pat(input int line);
    logic [511:0] r;
    for (int k = 0; k < 32; k++) r[16*k +: 16] = {line[7:0], k[7:0]};
    return r;
  endfunction

  function automatic logic [511:0] fill16(input logic [15:0] v);
    logic [511:0] r;
    for (int k = 0; k < 32; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [10:0] a,
                         input logic [511:0] d, input logic [31:0] m);
    req_write[i]          = w;
    req_addr[11*i +: 11]  = a;
    req_wdata[512*i +: 512] = d;
    req_mask[32*i +: 32]  = m;
  endtask

  task automatic pulse_reset();
    req_valid = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    // All requesters valid while reset is high: no grant may appear.
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    total++; if (wen64 !== 1'b0) begin bad++; $display("FAIL rst_wen64 got=%b exp=0", wen64); end
    total++; if (raddr0 !== 11'h000 || waddr64 !== 11'h000 || mask !== 32'h0) begin
      bad++; $display("FAIL rst_addr got=%h/%h/%h exp=0/0/0", raddr0, waddr64, mask); end
    total++; if (resp_valid !== 4'b0000 || resp_data !== 512'h0) begin
      bad++; $display("FAIL rst_resp got=%b/%h exp=0", resp_valid, resp_data); end
    total++; if (conflict_cnt !== 16'h0) begin bad++; $display("FAIL rst_conflict got=%h exp=0", conflict_cnt); end
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_read();
    step();
    set_req(0, 1'b0, 11'h010, fill16(16'hDEAD), 32'hFFFF_FFFF);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rd_ready got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    total++; if (raddr0 !== 11'h010 || wen64 !== 1'b0) begin
      bad++; $display("FAIL rd_issue got=%h/%b exp=010/0", raddr0, wen64); end
    total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL rd_early got=%b exp=0000", resp_valid); end
    step();
    total++; if (resp_valid !== 4'b0001) begin bad++; $display("FAIL rd_valid got=%b exp=0001", resp_valid); end
    total++; if (resp_data !== pat(16)) begin bad++; $display("FAIL rd_data got=%h exp=%h", resp_data, pat(16)); end
    step();
    total++; if (resp_valid !== 4'b0000 || resp_data !== pat(16)) begin
      bad++; $display("FAIL rd_hold got=%b/%h exp=0000/%h", resp_valid, resp_data, pat(16)); end
  endtask

  task automatic test_masked_write();
    logic [511:0] exp;
    exp = pat(32);
    exp[15:0] = 16'hBEEF;
    step();
    set_req(1, 1'b1, 11'h020, fill16(16'hBEEF), 32'h0000_0001);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wr_ready got=%b exp=0010", req_ready); end
    step();
    set_req(1, 1'b0, 11'h020, 512'h0, 32'h0);
    #1;
    total++; if (wen64 !== 1'b1 || waddr64 !== 11'h020 || mask !== 32'h1) begin
      bad++; $display("FAIL wr_issue got=%b/%h/%h exp=1/020/00000001", wen64, waddr64, mask); end
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wr_rd_ready got=%b exp=0010", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    total++; if (wen64 !== 1'b0 || raddr0 !== 11'h020) begin
      bad++; $display("FAIL wr_pulse got=%b/%h exp=0/020", wen64, raddr0); end
    step();
    total++; if (resp_valid !== 4'b0010 || resp_data !== exp) begin
      bad++; $display("FAIL wr_readback got=%b/%h exp=0010/%h", resp_valid, resp_data, exp); end
  endtask

  task automatic test_round_robin();
    int exp_g [7] = '{0, 1, 2, 3, 0, 1, 2};
    step();
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 11'(32'h100 + i), 512'h0, 32'h0);
    req_valid = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      #1;
      total++; if (req_ready !== 4'(1 << exp_g[c])) begin
        bad++; $display("FAIL rr_grant%0d got=%b exp=%b", c, req_ready, 4'(1 << exp_g[c])); end
      if (c >= 2) begin
        total++; if (resp_valid !== 4'(1 << exp_g[c-2]) || resp_data !== pat(256 + exp_g[c-2])) begin
          bad++; $display("FAIL rr_resp%0d got=%b exp=%b", c, resp_valid, 4'(1 << exp_g[c-2])); end
      end
      if (c == 5) begin
        total++; if (conflict_cnt !== 16'd5) begin bad++; $display("FAIL rr_cnt5 got=%0d exp=5", conflict_cnt); end
      end
      step();
    end
    req_valid = 4'b0101;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rr_wrap got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    total++; if (conflict_cnt !== 16'd8) begin bad++; $display("FAIL rr_cnt8 got=%0d exp=8", conflict_cnt); end
    step();
    step();
  endtask

  task automatic test_idle_hold();
    set_req(3, 1'b1, 11'h055, fill16(16'h5A5A), 32'hF0F0_0000);
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL idle_ready got=%b exp=1000", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    total++; if (wen64 !== 1'b1) begin bad++; $display("FAIL idle_wen got=%b exp=1", wen64); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (wen64 !== 1'b0 || resp_valid !== 4'b0000 || waddr64 !== 11'h055 || mask !== 32'hF0F0_0000) begin
        bad++; $display("FAIL idle_hold%0d got=%b/%b/%h/%h exp=0/0000/055/f0f00000",
                        c, wen64, resp_valid, waddr64, mask); end
    end
  endtask

  task automatic test_reset_mid();
    step();
    set_req(2, 1'b1, 11'h077, fill16(16'h1234), 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rm_ready got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    total++; if (wen64 !== 1'b1) begin bad++; $display("FAIL rm_wen_pre got=%b exp=1", wen64); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (wen64 !== 1'b0) begin bad++; $display("FAIL rm_wen_drop got=%b exp=0", wen64); end
    step();
    total++; if (mem[11'h077] !== pat(119)) begin
      bad++; $display("FAIL rm_line got=%h exp=%h", mem[11'h077], pat(119)); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 11'(32'h200 + i), 512'h0, 32'h0);
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_first got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    step();
  endtask

  task automatic test_saturation();
    pulse_reset();
    set_req(0, 1'b0, 11'h001, 512'h0, 32'h0);
    set_req(1, 1'b0, 11'h002, 512'h0, 32'h0);
    req_valid = 4'b0011;
    for (int c = 0; c < 65534; c++) step();
    total++; if (conflict_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", conflict_cnt); end
    step();
    total++; if (conflict_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h exp=ffff", conflict_cnt); end
    for (int c = 0; c < 4465; c++) step();
    total++; if (conflict_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); end
    req_valid = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_write = 4'b0000;
    req_addr  = '0;
    req_wdata = '0;
    req_mask  = '0;
    for (int l = 0; l < 2048; l++) mem[l] = pat(l);
    #3;
    test_reset();
    test_read();
    test_masked_write();
    test_round_robin();
    test_idle_hold();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
